ps2_key_tracker: RTL and testbench

- Sits directly downstream of the PS/2 receiver. Consumes its 32-bit scan-code history (`keycode`) and its make-code toggle flag (`key_flag`).
- Reconstructs the scan-code byte stream and parses set-2 prefixes (E0 for extended keys, F0 for break).
- Maintains held-state for 8 game keys and queues press/release events in a small FIFO with a valid/ready handshake to game logic.

---
 rtl/ps2_key_tracker.sv | 136 +++++++++++++
 tb/tb_ps2_key_tracker.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 key tracker: rebuilds the byte stream from the receiver history,
// tracks 8 game keys and queues press/release events. Optional: PS2_TYPEMATIC_EN.
module ps2_key_tracker #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] keycode,
  input  logic        key_flag,
  output logic [7:0]  key_held,
  output logic        evt_valid,
  output logic [3:0]  evt_data,
  input  logic        evt_ready,
  output logic        evt_overflow
);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} pstate_t;
  typedef struct packed {
    logic       rel;
    logic [2:0] idx;
  } evt_t;

  pstate_t          state, state_nxt;
  logic             primed;
  logic [31:0]      prev_code;
  logic             prev_flag;
  evt_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  logic       new_byte, is_make, is_brk, ext, hit, held;
  logic [7:0] byt;
  logic [2:0] idx;
  logic       push_make, set_held, clr_held, push, pop, full, do_push, drop;

  assign byt      = keycode[7:0];
  assign new_byte = primed & ((keycode != prev_code) | (key_flag != prev_flag));

  always_comb begin
    state_nxt = state;
    is_make   = 1'b0;
    is_brk    = 1'b0;
    ext       = 1'b0;
    if (new_byte) begin
      case (state)
        IDLE: begin
          if (byt == 8'hE0)      state_nxt = EXT;
          else if (byt == 8'hF0) state_nxt = BRK;
          else if (!(byt inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}))
            is_make = 1'b1;
        end
        EXT: begin
          if (byt == 8'hF0)      state_nxt = EXT_BRK;
          else if (byt != 8'hE0) begin
            is_make   = 1'b1;
            ext       = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          is_brk    = 1'b1;
          state_nxt = IDLE;
        end
        default: begin
          is_brk    = 1'b1;
          ext       = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Extended flag is part of the match key, so E0-5A never aliases Enter.
  always_comb begin
    hit = 1'b1;
    idx = 3'd0;
    case ({ext, byt})
      9'h01D:  idx = 3'd0;
      9'h01C:  idx = 3'd1;
      9'h01B:  idx = 3'd2;
      9'h023:  idx = 3'd3;
      9'h029:  idx = 3'd4;
      9'h05A:  idx = 3'd5;
      9'h175:  idx = 3'd6;
      9'h172:  idx = 3'd7;
      default: hit = 1'b0;
    endcase
  end

  assign held     = key_held[idx];
  assign set_held = is_make & hit & ~held;
  assign clr_held = is_brk & hit & held;
`ifdef PS2_TYPEMATIC_EN
  assign push_make = is_make & hit;
`else
  assign push_make = set_held;
`endif
  assign push    = push_make | clr_held;
  assign pop     = evt_valid & evt_ready;
  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;

  assign evt_valid = (count != '0);
  assign evt_data  = evt_valid ? mem[rd_ptr] : 4'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      primed       <= 1'b0;
      prev_code    <= '0;
      prev_flag    <= 1'b0;
      key_held     <= '0;
      evt_overflow <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      primed    <= 1'b1;
      prev_code <= keycode;
      prev_flag <= key_flag;
      state     <= state_nxt;
      if (set_held)      key_held[idx] <= 1'b1;
      else if (clr_held) key_held[idx] <= 1'b0;
      if (drop) evt_overflow <= 1'b1;
      if (do_push) begin
        mem[wr_ptr] <= '{rel: is_brk, idx: idx};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push & ~pop)      count <= count + (PTR_W+1)'(1);
      else if (pop & ~do_push) count <= count - (PTR_W+1)'(1);
    end
  end
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: expected events queued as bytes are driven,
// compared as the consumer pops them.
module tb_ps2_key_tracker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] keycode = '0;
  logic        key_flag = 1'b0;
  logic [7:0]  key_held;
  logic        evt_valid;
  logic [3:0]  evt_data;
  logic        evt_ready = 1'b0;
  logic        evt_overflow;

  int errors = 0;
  int checks = 0;
  logic [3:0] expq[$];
  logic [31:0] kc = '0;

  ps2_key_tracker #(.FIFO_DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .keycode(keycode), .key_flag(key_flag),
    .key_held(key_held), .evt_valid(evt_valid), .evt_data(evt_data),
    .evt_ready(evt_ready), .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Shift a byte into the history; makes and prefixes toggle the flag.
  task automatic put(input logic [7:0] b, input logic tog);
    kc = {kc[23:0], b};
    keycode = kc;
    if (tog) key_flag = ~key_flag;
    tick();
  endtask

  task automatic make(input logic [7:0] b);
    put(b, 1'b1);
  endtask

  task automatic brk(input logic [7:0] b);
    put(8'hF0, 1'b0);
    put(b, 1'b0);
  endtask

  task automatic drain(input string tag);
    while (expq.size() > 0) begin
      chk({tag, "_valid"}, evt_valid, 1'b1);
      chk({tag, "_data"}, evt_data, expq.pop_front());
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
    end
    chk({tag, "_empty"}, evt_valid, 1'b0);
  endtask

  initial begin
    tick(); tick();
    chk("rst_held", key_held, 8'h00);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_data", evt_data, 4'h0);
    chk("rst_ovf", evt_overflow, 1'b0);
    rst = 1'b0;
    tick();

    // single make, visible one cycle later
    make(8'h1D); expq.push_back(4'h0);
    chk("t1_held", key_held, 8'h01);
    drain("t1");
    brk(8'h1D); expq.push_back(4'h8);
    drain("t1rel");

    // make, typematic repeat, break
    make(8'h1D); expq.push_back(4'h0);
    key_flag = ~key_flag; tick();
`ifdef PS2_TYPEMATIC_EN
    expq.push_back(4'h0);
`endif
    chk("t2_rep_held", key_held, 8'h01);
    brk(8'h1D); expq.push_back(4'h8);
    chk("t2_kc", keycode, 32'h1D1DF01D);
    chk("t2_held", key_held, 8'h00);
    drain("t2");

    // extended keys, keypad Enter unmapped
    put(8'hE0, 1'b1); make(8'h75); expq.push_back(4'h6);
    chk("t3_up_held", key_held, 8'h40);
    put(8'hE0, 1'b1); brk(8'h75); expq.push_back(4'hE);
    put(8'hE0, 1'b1); make(8'h5A);
    chk("t3_kpent_held", key_held, 8'h00);
    make(8'h5A); expq.push_back(4'h5);
    chk("t3_ent_held", key_held, 8'h20);
    drain("t3");
    brk(8'h5A); expq.push_back(4'hD);
    drain("t3rel");

    // full FIFO with simultaneous pop and push
    make(8'h1D); make(8'h1C); make(8'h1B); make(8'h23);
    for (int i = 0; i < 4; i++) expq.push_back(4'(i));
    chk("t5_ovf0", evt_overflow, 1'b0);
    chk("t5_head0", evt_data, expq.pop_front());
    evt_ready = 1'b1;
    make(8'h29); expq.push_back(4'h4);
    evt_ready = 1'b0;
    chk("t5_ovf1", evt_overflow, 1'b0);
    chk("t5_held", key_held, 8'h1F);
    drain("t5");
    brk(8'h1D); brk(8'h1C); brk(8'h1B); brk(8'h23);
    for (int i = 0; i < 4; i++) expq.push_back(4'(8 + i));
    drain("t5rel_a");
    brk(8'h29); expq.push_back(4'hC);
    drain("t5rel_b");

    // overflow: 5 makes into 4 entries
    make(8'h1D); make(8'h1C); make(8'h1B); make(8'h23);
    chk("t4_ovf_pre", evt_overflow, 1'b0);
    make(8'h29);
    for (int i = 0; i < 4; i++) expq.push_back(4'(i));
    chk("t4_ovf", evt_overflow, 1'b1);
    chk("t4_held", key_held, 8'h1F);
    drain("t4");
    chk("t4_ovf_sticky", evt_overflow, 1'b1);

    // reset mid EXT_BRK with two queued events
    brk(8'h1D); brk(8'h1C);
    put(8'hE0, 1'b1); put(8'hF0, 1'b0);
    chk("t6_pre_valid", evt_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_held", key_held, 8'h00);
    chk("t6_valid", evt_valid, 1'b0);
    chk("t6_data", evt_data, 4'h0);
    chk("t6_ovf", evt_overflow, 1'b0);
    expq.delete();
    tick();
    rst = 1'b0;
    make(8'h1D);
    chk("t6_prime_held", key_held, 8'h00);
    chk("t6_prime_valid", evt_valid, 1'b0);
    tick();
    chk("t6_idle_valid", evt_valid, 1'b0);
    make(8'h1C); expq.push_back(4'h1);
    chk("t6_post_held", key_held, 8'h02);
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
